// File: rtl/fpu_sp_pkg.sv
// Shared constants and FSM encoding for the single-precision accumulate sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fpu_sp_pkg;

  // IEEE-754 single-precision constants used by the sequencer
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    FETCH = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } acc_state_e;

endpackage

// File: rtl/fpu_sp_acc_seq.sv
// Reduction sequencer: folds N fp32 operands into one sum through an external adder (acc + next).
// Latency: start->sum_valid is 2 cycles for N=0, else operand arrival plus adder latency per add.
// Backpressure: in_ready only in FIRST/FETCH; waits indefinitely on add_rdy unless FPU_ACC_TIMEOUT_EN.
// Optional build macro: FPU_ACC_TIMEOUT_EN adds a per-add watchdog (TIMEOUT_CYC) that sets err.
module fpu_sp_acc_seq
  import fpu_sp_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_dval,
  input  logic [31:0]      add_result,
  input  logic             add_rdy,
  output logic [31:0]      sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             err
);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [31:0]      sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             err_q, err_d;

  logic             in_xfer;
  logic             last_op;
  logic             wait_expired;

  assign in_xfer = in_valid & in_ready;
  // The operand being consumed now (stream word or add result) is the final one
  assign last_op = (remaining_q == CNT_W'(1));

`ifdef FPU_ACC_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  // Watchdog counter: cleared on the way into WAIT, counts every WAIT cycle
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + WC_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYC-th WAIT cycle that still has no result
  assign wait_expired = (state_q == WAIT) && !add_rdy &&
                        (wait_cnt_q == WC_W'(TIMEOUT_CYC - 1));
`else
  // Without the watchdog the limit has no effect; WAIT only exits on add_rdy
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign wait_expired       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (len == '0) ? DONE : FIRST;
      FIRST: if (in_xfer) state_d = last_op ? DONE : FETCH;
      FETCH: if (in_xfer) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (add_rdy) begin
          state_d = last_op ? DONE : FETCH;
        end else if (wait_expired) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    add_dval = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      IDLE:         busy     = 1'b0;
      FIRST, FETCH: in_ready = 1'b1;
      ISSUE:        add_dval = 1'b1;
      default:      ;
    endcase
  end

  // Datapath: accumulator, operand count, adder operands and result capture
  always_comb begin
    remaining_d = remaining_q;
    acc_d       = acc_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = len;
          err_d       = 1'b0;
          if (len == '0) acc_d = FP_POS_ZERO;
        end
      end
      FIRST: begin
        // First operand is loaded directly so a lone -0.0 keeps its sign
        if (in_xfer) begin
          acc_d       = in_data;
          remaining_d = remaining_q - CNT_W'(1);
        end
      end
      FETCH: begin
        if (in_xfer) begin
          add_a_d = acc_q;
          add_b_d = in_data;
        end
      end
      WAIT: begin
        // Results are taken verbatim, NaN/Inf included
        if (add_rdy) begin
          acc_d       = add_result;
          remaining_d = remaining_q - CNT_W'(1);
        end else if (wait_expired) begin
          acc_d = FP_QNAN;
          err_d = 1'b1;
        end
      end
      DONE: begin
        sum_d       = acc_q;
        sum_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      acc_q       <= FP_POS_ZERO;
      add_a_q     <= FP_POS_ZERO;
      add_b_q     <= FP_POS_ZERO;
      sum_q       <= FP_POS_ZERO;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      err_q       <= err_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign err       = err_q;

endmodule
